// File: rtl/lorenz_step_scheduler.sv
// Lorenz Euler-step sequencer: time-multiplexes one external 7.20 multiplier over the
// four products of a step and streams each new x/y/z state over valid/ready.
module lorenz_step_scheduler #(
    parameter int N        = 27,
    parameter int DT_SHIFT = 8,
    parameter int STEP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [N-1:0]      sigma,
    input  logic [N-1:0]      rho,
    input  logic [N-1:0]      beta,
    input  logic [N-1:0]      x0,
    input  logic [N-1:0]      y0,
    input  logic [N-1:0]      z0,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic [N-1:0]      mul_p,
    output logic [N-1:0]      x,
    output logic [N-1:0]      y,
    output logic [N-1:0]      z,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        fsm_state
);

    // sample_valid/sample_ready: a sample transfers on a rising edge where both are high;
    // while valid is high x/y/z stay stable, and valid drops only after a transfer.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL0 = 3'd2,
        S_MUL1 = 3'd3,
        S_MUL2 = 3'd4,
        S_MUL3 = 3'd5,
        S_UPD  = 3'd6,
        S_EMIT = 3'd7
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] steps_r;
    logic [STEP_W-1:0] count;
    logic [N-1:0]      sigma_r;
    logic [N-1:0]      rho_r;
    logic [N-1:0]      beta_r;
    logic [N-1:0]      x0_r;
    logic [N-1:0]      y0_r;
    logic [N-1:0]      z0_r;
    logic [N-1:0]      p1;
    logic [N-1:0]      p2;
    logic [N-1:0]      p3;
    logic [N-1:0]      p4;

    logic [N-1:0] dx_v;
    logic [N-1:0] dy_v;
    logic [N-1:0] dz_v;

    // Multiplying by dt is a pure arithmetic shift of the state.
    assign dx_v = N'($signed(x) >>> DT_SHIFT);
    assign dy_v = N'($signed(y) >>> DT_SHIFT);
    assign dz_v = N'($signed(z) >>> DT_SHIFT);

    assign fsm_state = state;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MUL0: begin
                mul_a = dy_v - dx_v;
                mul_b = sigma_r;
            end
            S_MUL1: begin
                mul_a = dx_v;
                mul_b = rho_r - z;
            end
            S_MUL2: begin
                mul_a = dx_v;
                mul_b = y;
            end
            S_MUL3: begin
                mul_a = dz_v;
                mul_b = beta_r;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            steps_r      <= '0;
            count        <= '0;
            sigma_r      <= '0;
            rho_r        <= '0;
            beta_r       <= '0;
            x0_r         <= '0;
            y0_r         <= '0;
            z0_r         <= '0;
            p1           <= '0;
            p2           <= '0;
            p3           <= '0;
            p4           <= '0;
            x            <= '0;
            y            <= '0;
            z            <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_steps != '0) begin
                            steps_r <= num_steps;
                            sigma_r <= sigma;
                            rho_r   <= rho;
                            beta_r  <= beta;
                            x0_r    <= x0;
                            y0_r    <= y0;
                            z0_r    <= z0;
                            busy    <= 1'b1;
                            state   <= S_LOAD;
                        end else begin
                            // A zero-length run completes immediately without touching state.
                            done <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    x     <= x0_r;
                    y     <= y0_r;
                    z     <= z0_r;
                    count <= '0;
                    state <= S_MUL0;
                end
                S_MUL0: begin
                    p1    <= mul_p;
                    state <= S_MUL1;
                end
                S_MUL1: begin
                    p2    <= mul_p;
                    state <= S_MUL2;
                end
                S_MUL2: begin
                    p3    <= mul_p;
                    state <= S_MUL3;
                end
                S_MUL3: begin
                    p4    <= mul_p;
                    state <= S_UPD;
                end
                S_UPD: begin
                    x            <= x + p1;
                    y            <= y + p2 - dy_v;
                    z            <= z + p3 - p4;
                    count        <= count + 1'b1;
                    sample_valid <= 1'b1;
                    state        <= S_EMIT;
                end
                S_EMIT: begin
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        if (count == steps_r) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_MUL0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
